// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between two byte requesters, the shared FIFO write port
// and the FIFO read-side pop strobe.
//   req0_* / req1_* : per-requester valid/data/last in, rdy out
//   fifo_wr_en/data : write strobe and data toward the FIFO
//   fifo_wr_vld     : FIFO can take a write this cycle
//   fifo_pop        : one entry consumed on the FIFO read side
// slave  = arbiter side, master = requesters + FIFO environment.
interface fifo_wr_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              req0_vld;
    logic [DATA_W-1:0] req0_data;
    logic              req0_last;
    logic              req0_rdy;

    logic              req1_vld;
    logic [DATA_W-1:0] req1_data;
    logic              req1_last;
    logic              req1_rdy;

    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic              fifo_wr_vld;
    logic              fifo_pop;

    modport slave (
        input  req0_vld, req0_data, req0_last,
        input  req1_vld, req1_data, req1_last,
        input  fifo_wr_vld, fifo_pop,
        output req0_rdy, req1_rdy,
        output fifo_wr_en, fifo_wr_data
    );

    modport master (
        output req0_vld, req0_data, req0_last,
        output req1_vld, req1_data, req1_last,
        output fifo_wr_vld, fifo_pop,
        input  req0_rdy, req1_rdy,
        input  fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Two-requester, packet-granular round-robin arbiter writing into a shared
// synchronous FIFO. Tracks FIFO occupancy, counts completed packets per
// requester and flags pops from an empty FIFO.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : fifo_wr_arbiter_if.slave handshake bundle
//   level      : registered FIFO occupancy, 0..DEPTH
//   pkt_cnt0/1 : completed packets per requester, wrapping 16-bit
//   err_udf    : sticky, pop seen while level was 0
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no grant; pick next requester (round robin)
// GNT0  | requester 0 owns the FIFO until its last beat
// GNT1  | requester 1 owns the FIFO until its last beat
module fifo_wr_arbiter #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2048,
    parameter int LVL_W  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_wr_arbiter_if.slave bus,
    output logic [LVL_W-1:0] level,
    output logic [15:0]      pkt_cnt0,
    output logic [15:0]      pkt_cnt1,
    output logic             err_udf
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);
    localparam logic [DATA_W-1:0] ZERO_DATA = '0;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    // Last granted requester; reset to 1 so requester 0 wins the first tie.
    logic              rr_ptr;
    logic              not_full;
    logic              rdy0;
    logic              rdy1;
    logic              acc0;
    logic              acc1;
    logic              wr_en;
    logic              pop_ok;
    logic [DATA_W-1:0] wr_data;

    // Full check uses the registered level only, so a pop in the same cycle
    // frees space for a write no earlier than the following cycle.
    assign not_full = (level < FULL_LVL);
    assign rdy0     = (state == GNT0) & bus.fifo_wr_vld & not_full;
    assign rdy1     = (state == GNT1) & bus.fifo_wr_vld & not_full;
    assign acc0     = rdy0 & bus.req0_vld;
    assign acc1     = rdy1 & bus.req1_vld;
    assign wr_en    = acc0 | acc1;
    assign pop_ok   = bus.fifo_pop & (level != '0);

    assign bus.req0_rdy     = rdy0;
    assign bus.req1_rdy     = rdy1;
    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_wr_data = wr_data;

    always_comb begin
        wr_data = ZERO_DATA;
        case (state)
            GNT0:    wr_data = bus.req0_data;
            GNT1:    wr_data = bus.req1_data;
            default: wr_data = ZERO_DATA;
        endcase
    end

    // Grant is held until the last beat is accepted, even if the owner
    // drops vld mid-packet.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req0_vld && bus.req1_vld) begin
                    state_nxt = rr_ptr ? GNT0 : GNT1;
                end else if (bus.req0_vld) begin
                    state_nxt = GNT0;
                end else if (bus.req1_vld) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (acc0 && bus.req0_last) begin
                    state_nxt = IDLE;
                end
            end
            GNT1: begin
                if (acc1 && bus.req1_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == GNT0) begin
                rr_ptr <= 1'b0;
            end else if (state == IDLE && state_nxt == GNT1) begin
                rr_ptr <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else begin
            case ({wr_en, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (acc0 && bus.req0_last) begin
                pkt_cnt0 <= pkt_cnt0 + 16'd1;
            end
            if (acc1 && bus.req1_last) begin
                pkt_cnt1 <= pkt_cnt1 + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_udf <= 1'b0;
        end else if (bus.fifo_pop && level == '0) begin
            err_udf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 2048;
    localparam int LVL_W  = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [LVL_W-1:0] level;
    logic [15:0]      pkt_cnt0;
    logic [15:0]      pkt_cnt1;
    logic             err_udf;

    fifo_wr_arbiter_if #(.DATA_W(DATA_W)) bus();

    fifo_wr_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .level    (level),
        .pkt_cnt0 (pkt_cnt0),
        .pkt_cnt1 (pkt_cnt1),
        .err_udf  (err_udf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait budget expired at %0t", name, $time);
    endtask

    // ---------------- packet sources ----------------
    int         plen[2] = '{4, 4};
    int         left[2] = '{0, 0};
    bit         en[2]   = '{1'b0, 1'b0};
    bit         hold[2] = '{1'b0, 1'b0};
    int         beat[2] = '{0, 0};
    logic [7:0] dcnt[2] = '{8'h00, 8'h00};

    task automatic drive_src();
        bus.req0_vld  = en[0] && !hold[0] && (left[0] > 0);
        bus.req0_data = dcnt[0];
        bus.req0_last = (beat[0] == plen[0] - 1);
        bus.req1_vld  = en[1] && !hold[1] && (left[1] > 0);
        bus.req1_data = dcnt[1] ^ 8'hA5;
        bus.req1_last = (beat[1] == plen[1] - 1);
    endtask

    task automatic advance_src(input int n);
        dcnt[n] = dcnt[n] + 8'd1;
        if (beat[n] == plen[n] - 1) begin
            beat[n] = 0;
            left[n] = left[n] - 1;
        end else begin
            beat[n] = beat[n] + 1;
        end
    endtask

    initial begin : driver
        logic a0, a1;
        drive_src();
        forever begin
            @(negedge clk);
            a0 = bus.req0_vld & bus.req0_rdy;
            a1 = bus.req1_vld & bus.req1_rdy;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                beat[0] = 0;
                beat[1] = 0;
            end else begin
                if (a0) advance_src(0);
                if (a1) advance_src(1);
            end
            drive_src();
        end
    end

    // ---------------- behavioural model ----------------
    // FIFO contents as a queue; owner = requester holding the packet grant
    // (-1 none); lastg = most recently granted requester.
    logic [7:0] mq[$];
    int         owner;
    int         lastg;
    int         pc0;
    int         pc1;
    bit         merr;

    task automatic m_reset();
        mq.delete();
        owner = -1;
        lastg = 1;
        pc0   = 0;
        pc1   = 0;
        merr  = 1'b0;
    endtask

    initial begin : model
        logic       v0, v1, l0, l1, wv, pp;
        logic [7:0] d0, d1;
        bit         r0, r1, we;
        logic [7:0] ed;
        m_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) m_reset();
            r0 = rst_n && owner == 0 && bus.fifo_wr_vld && mq.size() < DEPTH;
            r1 = rst_n && owner == 1 && bus.fifo_wr_vld && mq.size() < DEPTH;
            we = (r0 && bus.req0_vld) || (r1 && bus.req1_vld);
            ed = (owner == 0) ? bus.req0_data : (owner == 1) ? bus.req1_data : 8'h00;
            chk("req0_rdy", bus.req0_rdy, r0);
            chk("req1_rdy", bus.req1_rdy, r1);
            chk("fifo_wr_en", bus.fifo_wr_en, we);
            chk("fifo_wr_data", bus.fifo_wr_data, ed);
            chk("level", level, mq.size());
            chk("pkt_cnt0", pkt_cnt0, pc0);
            chk("pkt_cnt1", pkt_cnt1, pc1);
            chk("err_udf", err_udf, merr);

            @(posedge clk);
            v0 = bus.req0_vld;  d0 = bus.req0_data;  l0 = bus.req0_last;
            v1 = bus.req1_vld;  d1 = bus.req1_data;  l1 = bus.req1_last;
            wv = bus.fifo_wr_vld;
            pp = bus.fifo_pop;
            if (!rst_n) begin
                m_reset();
            end else begin
                r0 = owner == 0 && wv && mq.size() < DEPTH;
                r1 = owner == 1 && wv && mq.size() < DEPTH;
                we = (r0 && v0) || (r1 && v1);
                if (pp) begin
                    if (mq.size() == 0) merr = 1'b1;
                    else void'(mq.pop_front());
                end
                if (we) mq.push_back(owner == 0 ? d0 : d1);
                if (owner < 0) begin
                    if (v0 && v1) owner = (lastg == 0) ? 1 : 0;
                    else if (v0)  owner = 0;
                    else if (v1)  owner = 1;
                    if (owner >= 0) lastg = owner;
                end else if (we && (owner == 0 ? l0 : l1)) begin
                    if (owner == 0) pc0 = (pc0 + 1) % 65536;
                    else            pc1 = (pc1 + 1) % 65536;
                    owner = -1;
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic at_pos();
        @(posedge clk);
        #2;
    endtask

    task automatic pop_cycles(input int n);
        if (n > 0) begin
            @(negedge clk);
            #1 bus.fifo_pop = 1'b1;
            repeat (n) @(negedge clk);
            #1 bus.fifo_pop = 1'b0;
        end
    endtask

    initial begin : main
        int t, first, lastw, nwr, pat;
        bit prev_we, seen4;
        int who[$];
        int r0c, wc;

        rst_n           = 1'b1;
        bus.fifo_wr_vld = 1'b0;
        bus.fifo_pop    = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_err", err_udf, 0);
        chk("rst_pkt0", pkt_cnt0, 0);
        chk("rst_rdy0", bus.req0_rdy, 0);
        chk("rst_wr_en", bus.fifo_wr_en, 0);

        // both requesters stream 4-byte packets, alternating grants
        at_pos();
        plen[0] = 4; plen[1] = 4; left[0] = 3; left[1] = 2;
        bus.fifo_wr_vld = 1'b1;
        en[0] = 1'b1; en[1] = 1'b1;
        first = -1; lastw = -1; nwr = 0; prev_we = 1'b0; seen4 = 1'b0;
        who.delete();
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (bus.fifo_wr_en) begin
                if (!prev_we) who.push_back(bus.req1_rdy ? 1 : 0);
                if (first < 0) first = i;
                lastw = i;
                nwr++;
            end
            prev_we = bus.fifo_wr_en;
            if (!seen4 && (pkt_cnt0 + pkt_cnt1 == 16'd4)) begin
                seen4 = 1'b1;
                chk("rr_level_after_4pkt", level, 16);
            end
        end
        pat = 0;
        foreach (who[i]) pat = pat * 2 + who[i];
        chk("rr_writes", nwr, 20);
        chk("rr_span", lastw - first, 23);
        chk("rr_bursts", who.size(), 5);
        chk("rr_order_01010", pat, 10);
        chk("rr_level_20", level, 20);
        chk("rr_pkt0", pkt_cnt0, 3);
        chk("rr_pkt1", pkt_cnt1, 2);
        en[0] = 1'b0; en[1] = 1'b0;
        pop_cycles(mq.size());
        @(negedge clk);
        chk("drain_level", level, 0);

        // pop from empty FIFO
        #1 bus.fifo_pop = 1'b1;
        @(negedge clk);
        chk("udf_level", level, 0);
        chk("udf_err", err_udf, 1);
        #1 bus.fifo_pop = 1'b0;
        repeat (3) @(negedge clk);
        chk("udf_err_sticky", err_udf, 1);

        // simultaneous write and pop at level 5
        at_pos();
        plen[0] = 6; left[0] = 1; en[0] = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (level != 12'd5 && t < 40);
        if (level != 12'd5) tmo("wait_level5");
        chk("wp_wr_en", bus.fifo_wr_en, 1);
        #1 bus.fifo_pop = 1'b1;
        @(negedge clk);
        chk("wp_level5", level, 5);
        #1 bus.fifo_pop = 1'b0;
        en[0] = 1'b0;
        pop_cycles(mq.size());

        // req1 stalls mid-packet; req0 must wait
        at_pos();
        plen[0] = 2; left[0] = 1;
        plen[1] = 4; left[1] = 1; en[1] = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (beat[1] != 2 && t < 30);
        if (beat[1] != 2) tmo("wait_req1_beat2");
        hold[1] = 1'b1;
        en[0]   = 1'b1;
        r0c = 0; wc = 0;
        repeat (10) begin
            @(negedge clk);
            r0c += int'(bus.req0_rdy);
            wc  += int'(bus.fifo_wr_en);
        end
        chk("stall_rdy0", r0c, 0);
        chk("stall_wr_en", wc, 0);
        hold[1] = 1'b0;
        who.delete();
        repeat (12) begin
            @(negedge clk);
            if (bus.fifo_wr_en) who.push_back(bus.req1_rdy ? 1 : 0);
        end
        pat = 0;
        foreach (who[i]) pat = pat * 2 + who[i];
        chk("stall_writes", who.size(), 3);
        chk("stall_order_100", pat, 4);
        chk("stall_level", level, 6);
        en[0] = 1'b0; en[1] = 1'b0;
        pop_cycles(mq.size());

        // fill to DEPTH, then one pop frees exactly one write
        at_pos();
        plen[0] = 3; left[0] = 1000; en[0] = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (level != 12'd2048 && t < 3200);
        if (level != 12'd2048) tmo("wait_full");
        chk("full_level", level, 2048);
        chk("full_rdy0", bus.req0_rdy, 0);
        @(negedge clk);
        chk("full_hold_level", level, 2048);
        chk("full_hold_wr_en", bus.fifo_wr_en, 0);
        #1 bus.fifo_pop = 1'b1;
        #1 chk("full_pop_rdy0", bus.req0_rdy, 0);
        @(negedge clk);
        chk("full_after_pop_level", level, 2047);
        chk("full_after_pop_wr_en", bus.fifo_wr_en, 1);
        #1 bus.fifo_pop = 1'b0;
        @(negedge clk);
        chk("full_refill_level", level, 2048);
        chk("full_refill_rdy0", bus.req0_rdy, 0);

        // clear, then reset during the 3rd beat of a packet
        #1 rst_n = 1'b0;
        en[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        at_pos();
        plen[0] = 4; left[0] = 1; en[0] = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!(beat[0] == 2 && bus.fifo_wr_en) && t < 30);
        if (!(beat[0] == 2 && bus.fifo_wr_en)) tmo("wait_beat3");
        chk("pre_rst_level", level, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_rdy0", bus.req0_rdy, 0);
        chk("arst_wr_en", bus.fifo_wr_en, 0);
        chk("arst_wr_data", bus.fifo_wr_data, 0);
        chk("arst_level", level, 0);
        chk("arst_pkt0", pkt_cnt0, 0);
        chk("arst_err", err_udf, 0);
        plen[1] = 4; left[1] = 1; en[1] = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        who.delete();
        prev_we = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (bus.fifo_wr_en && !prev_we) who.push_back(bus.req1_rdy ? 1 : 0);
            prev_we = bus.fifo_wr_en;
        end
        pat = 0;
        foreach (who[i]) pat = pat * 2 + who[i];
        chk("post_rst_bursts", who.size(), 2);
        chk("post_rst_order_01", pat, 1);
        chk("post_rst_level", level, 8);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
